in_line_offset_former: RTL and testbench
========================================

Name: in_line_offset_former

Overview:
Splits one image/memory line into a sequence of AXI-style burst descriptors (byte offset and burst length) for the DMA address generator. A line request carries the line size in data words minus one. The block emits one descriptor per burst over a valid/ready handshake and flags the final burst of the line with last_o.

Parameters:
ADDR_W, 32, width of line size and byte offset.
DATA_W, 64, data bus width in bits; power of 2, at least 8. Bytes per word BPW = DATA_W/8.
MAX_BURST_LEN, 15, maximum burst length in AXI len encoding (beats-1). Range 0..255. Full burst = MAX_BURST_LEN+1 beats.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  asynchronous, active-low reset.
new_line_i  in  1  start a line; sampled only in IDLE.
line_size_i  in  ADDR_W  line length in words minus 1; sampled with new_line_i.
offset_o  out  ADDR_W  byte offset of the current burst from line start.
burst_len_o  out  8  beats-1 of the current burst.
valid_o  out  1  descriptor valid.
last_o  out  1  current descriptor is the final burst of the line; 0 whenever valid_o=0.
ready_i  in  1  consumer accepts the descriptor when valid_o&ready_i.

Behaviour:
- Reset (rst_i=0, async): state IDLE; valid_o=0, last_o=0, offset_o=0, burst_len_o=0, internal remaining=0.
- All outputs are registered.
- FBW = MAX_BURST_LEN+1 words per full burst. FBB = FBW*BPW bytes per full burst.
- Internal register rem (ADDR_W bits) holds remaining words minus 1.
- IDLE, new_line_i=1 at a clock edge:
  - Load rem=line_size_i and offset_o=0.
  - Set valid_o=1, burst_len_o=min(line_size_i, MAX_BURST_LEN), last_o=(line_size_i<=MAX_BURST_LEN).
  - Go to BUSY. First descriptor is visible one cycle after new_line_i is sampled.
- BUSY, valid_o=1, ready_i=0: all outputs hold stable.
- BUSY, handshake (valid_o&ready_i), last_o=0:
  - rem -= FBW; offset_o += FBB.
  - burst_len_o=min(new rem, MAX_BURST_LEN); last_o=(new rem<=MAX_BURST_LEN); valid_o stays 1.
  - Back-to-back handshakes yield one descriptor per cycle.
- BUSY, handshake with last_o=1:
  - If new_line_i=0: valid_o=0, last_o=0, go to IDLE. offset_o and burst_len_o keep their last values.
  - If new_line_i=1 on that same edge: start the new line directly as from IDLE, with no bubble cycle.
- new_line_i while BUSY, other than on the final handshake: ignored. line_size_i is don't-care after it is sampled.
- Burst count per line = ceil((line_size_i+1)/FBW). Final burst_len_o = line_size_i mod FBW.
- line_size_i=0: a single descriptor, burst_len_o=0, last_o=1.
- Arithmetic is unsigned, modulo 2^ADDR_W. A line whose byte length exceeds 2^ADDR_W is out of contract.
- burst_len_o is zero-extended or truncated to 8 bits; MAX_BURST_LEN<=255 guarantees no loss.

Decomposition:
- Shared package (dma_pkg): constants BPW=DATA_W/8, FBW=MAX_BURST_LEN+1, FBB=FBW*BPW as localparam functions, and the state enum {IDLE, BUSY}.
- Single flat module with no sub-module. A helper function for min(rem, MAX_BURST_LEN) lives in the package.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles -> valid_o=0, last_o=0, offset_o=0, burst_len_o=0. Release; outputs stay idle without new_line_i.
- line_size_i=59, ready_i=1, single new_line_i pulse -> four consecutive descriptors:
  - offset_o 0/128/256/384, burst_len_o 15/15/15/11.
  - last_o only on the 4th; valid_o drops the next cycle.
- new_line_i held high with line_size_i=59 -> after the 4th handshake, a new line restarts immediately at offset 0 with no idle cycle.
- line_size_i=30, ready_i pulsed one cycle every ~7 cycles -> descriptors (0,15,last=0) then (128,14,last=1). Outputs stable while ready_i=0. Exactly two handshakes.
- line_size_i=0 -> one descriptor (0,0,last=1). line_size_i=15 -> one descriptor (0,15,last=1). line_size_i=16 -> (0,15,0) then (128,0,1).
- Assert rst_i mid-line (after 2nd descriptor) -> outputs clear asynchronously. Next new_line_i starts fresh at offset 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants and types for the DMA line-splitting blocks.
//   state_t   : line former FSM states
//   calc_bpw  : bytes per data word
//   calc_fbw  : words per full burst
//   calc_fbb  : bytes per full burst
//   clamp_len : min(rem, max_len), returned in 8-bit AXI len encoding
package dma_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int unsigned calc_bpw(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned calc_fbw(input int unsigned max_burst_len);
    return max_burst_len + 1;
  endfunction

  function automatic int unsigned calc_fbb(input int unsigned max_burst_len,
                                           input int unsigned data_w);
    return calc_fbw(max_burst_len) * calc_bpw(data_w);
  endfunction

  // rem is passed zero-extended to 64 bits so one helper serves any ADDR_W
  // up to 64.
  function automatic logic [7:0] clamp_len(input logic [63:0]   rem,
                                           input int unsigned   max_len);
    logic [31:0] max_v;
    max_v = max_len;
    if (rem > {32'd0, max_v}) return max_v[7:0];
    else                      return rem[7:0];
  endfunction

endpackage

// File: rtl/in_line_offset_former.sv
// Splits one line into burst descriptors (byte offset, AXI len) for the DMA
// address generator. One descriptor per valid/ready handshake; last_o marks
// the final burst of the line.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   new_line_i   start a line (taken in IDLE or on the final handshake)
//   line_size_i  line length in words minus 1, sampled with new_line_i
//   offset_o     byte offset of current burst from line start
//   burst_len_o  beats-1 of current burst
//   valid_o      descriptor valid
//   last_o       final burst of the line (0 when valid_o=0)
//   ready_i      consumer accepts descriptor when valid_o & ready_i
//
// state | meaning
// IDLE  | no line in progress, waiting for new_line_i
// BUSY  | presenting descriptors of the current line
module in_line_offset_former
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned MAX_BURST_LEN = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              new_line_i,
  input  logic [ADDR_W-1:0] line_size_i,
  output logic [ADDR_W-1:0] offset_o,
  output logic [7:0]        burst_len_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i
);

  localparam int unsigned FBW = calc_fbw(MAX_BURST_LEN);
  localparam int unsigned FBB = calc_fbb(MAX_BURST_LEN, DATA_W);

  localparam logic [ADDR_W-1:0] FBW_A = ADDR_W'(FBW);
  localparam logic [ADDR_W-1:0] FBB_A = ADDR_W'(FBB);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_BURST_LEN);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] offset_d;
  logic [7:0]        burst_len_d;
  logic              valid_d, last_d;

  logic              handshake;
  logic              start_line;
  logic [ADDR_W-1:0] rem_next;

  assign handshake  = valid_o & ready_i;
  // A new line may also start on the final handshake so back-to-back lines
  // have no bubble cycle.
  assign start_line = new_line_i & ((state_q == IDLE) | (handshake & last_o));
  assign rem_next   = rem_q - FBW_A;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    offset_d    = offset_o;
    burst_len_d = burst_len_o;
    valid_d     = valid_o;
    last_d      = last_o;

    if (start_line) begin
      state_d     = BUSY;
      rem_d       = line_size_i;
      offset_d    = '0;
      burst_len_d = clamp_len(64'(line_size_i), MAX_BURST_LEN);
      valid_d     = 1'b1;
      last_d      = (line_size_i <= MAX_A);
    end else if ((state_q == BUSY) && handshake) begin
      if (last_o) begin
        // offset and burst length intentionally keep their final values
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        rem_d       = rem_next;
        offset_d    = offset_o + FBB_A;
        burst_len_d = clamp_len(64'(rem_next), MAX_BURST_LEN);
        last_d      = (rem_next <= MAX_A);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      offset_o    <= '0;
      burst_len_o <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      offset_o    <= offset_d;
      burst_len_o <= burst_len_d;
      valid_o     <= valid_d;
      last_o      <= last_d;
    end
  end

endmodule

// File: tb/tb_in_line_offset_former.sv
// Directed self-checking bench for in_line_offset_former (DATA_W=64,
// MAX_BURST_LEN=15: 16 words / 128 bytes per full burst).
// Inputs are driven and outputs sampled on the falling edge.
module tb_in_line_offset_former;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        new_line_i;
  logic [31:0] line_size_i;
  logic [31:0] offset_o;
  logic [7:0]  burst_len_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int hs_base;

  in_line_offset_former #(
    .ADDR_W(32), .DATA_W(64), .MAX_BURST_LEN(15)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .new_line_i  (new_line_i),
    .line_size_i (line_size_i),
    .offset_o    (offset_o),
    .burst_len_o (burst_len_o),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .ready_i     (ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (valid_o && ready_i) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_desc(input string tag, input logic [31:0] off,
                          input logic [7:0] bl, input logic lst);
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".off"},   offset_o, off);
    chk({tag, ".len"},   32'(burst_len_o), 32'(bl));
    chk({tag, ".last"},  32'(last_o), 32'(lst));
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] off, input logic [7:0] bl);
    chk({tag, ".valid"}, 32'(valid_o), 32'd0);
    chk({tag, ".last"},  32'(last_o), 32'd0);
    chk({tag, ".off"},   offset_o, off);
    chk({tag, ".len"},   32'(burst_len_o), 32'(bl));
  endtask

  // called on a falling edge; returns on the falling edge where the first
  // descriptor is visible
  task automatic start(input logic [31:0] size);
    new_line_i  = 1'b1;
    line_size_i = size;
    @(negedge clk_i);
    new_line_i  = 1'b0;
    line_size_i = 32'hDEAD_BEEF;
  endtask

  initial begin
    rst_i = 1'b0; new_line_i = 1'b0; line_size_i = '0; ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_idle("rst", 32'd0, 8'd0);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk_idle("post_rst", 32'd0, 8'd0);

    // 60-word line, consumer always ready
    ready_i = 1'b1;
    start(32'd59);
    chk_desc("l59_d0", 32'd0, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("l59_d1", 32'd128, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("l59_d2", 32'd256, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("l59_d3", 32'd384, 8'd11, 1'b1);
    @(negedge clk_i); chk_idle("l59_end", 32'd384, 8'd11);

    // new_line_i held: ignored mid-line, restarts with no bubble at the end
    new_line_i = 1'b1; line_size_i = 32'd59;
    @(negedge clk_i); chk_desc("hold_d0", 32'd0, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("hold_d1", 32'd128, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("hold_d2", 32'd256, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("hold_d3", 32'd384, 8'd11, 1'b1);
    @(negedge clk_i); chk_desc("hold_r0", 32'd0, 8'd15, 1'b0);
    new_line_i = 1'b0;
    @(negedge clk_i); chk_desc("hold_r1", 32'd128, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("hold_r2", 32'd256, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("hold_r3", 32'd384, 8'd11, 1'b1);
    @(negedge clk_i); chk_idle("hold_end", 32'd384, 8'd11);

    // 31-word line with slow consumer
    ready_i = 1'b0;
    hs_base = hs_cnt;
    start(32'd30);
    chk_desc("l30_d0", 32'd0, 8'd15, 1'b0);
    repeat (6) @(negedge clk_i);
    chk_desc("l30_d0_hold", 32'd0, 8'd15, 1'b0);
    ready_i = 1'b1;
    @(negedge clk_i); ready_i = 1'b0;
    chk_desc("l30_d1", 32'd128, 8'd14, 1'b1);
    repeat (6) @(negedge clk_i);
    chk_desc("l30_d1_hold", 32'd128, 8'd14, 1'b1);
    ready_i = 1'b1;
    @(negedge clk_i); ready_i = 1'b0;
    chk_idle("l30_end", 32'd128, 8'd14);
    repeat (7) @(negedge clk_i);
    chk("l30_hs_cnt", 32'(hs_cnt - hs_base), 32'd2);

    // boundary sizes
    ready_i = 1'b1;
    start(32'd0);
    chk_desc("l0_d0", 32'd0, 8'd0, 1'b1);
    @(negedge clk_i); chk_idle("l0_end", 32'd0, 8'd0);
    start(32'd15);
    chk_desc("l15_d0", 32'd0, 8'd15, 1'b1);
    @(negedge clk_i); chk_idle("l15_end", 32'd0, 8'd15);
    start(32'd16);
    chk_desc("l16_d0", 32'd0, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("l16_d1", 32'd128, 8'd0, 1'b1);
    @(negedge clk_i); chk_idle("l16_end", 32'd128, 8'd0);

    // asynchronous reset mid-line
    start(32'd59);
    chk_desc("rl_d0", 32'd0, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("rl_d1", 32'd128, 8'd15, 1'b0);
    #2 rst_i = 1'b0;
    #1 chk_idle("rl_async", 32'd0, 8'd0);
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); chk_idle("rl_idle", 32'd0, 8'd0);
    start(32'd16);
    chk_desc("rl_n0", 32'd0, 8'd15, 1'b0);
    @(negedge clk_i); chk_desc("rl_n1", 32'd128, 8'd0, 1'b1);
    @(negedge clk_i); chk_idle("rl_nend", 32'd128, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
